// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and framing constants.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam logic [3:0] WMASK_WORD        = 4'b1111;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into little-endian 32-bit words; full flags the 4th byte of a word.
module word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        full
);

   logic [3:0][7:0] lanes;
   logic [1:0]      byte_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes    <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (load) begin
         lanes[byte_idx] <= din;
         byte_idx        <= byte_idx + 2'd1;
      end
   end

   assign word = lanes;
   assign full = load && (byte_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a framed byte stream, writes it into instruction memory and
// releases the core once a frame with a good checksum completes.
module prog_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W    = 11,
   parameter int         MAX_WORDS = 512,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   output logic              rx_ready_o,
   input  logic [ADDR_W-1:0] core_instr_addr_i,
   output logic              core_reset_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wen_o,
   output logic [3:0]        mem_wmask_o,
   output logic [31:0]       mem_data_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int IDX_W = ADDR_W - 2;

   state_t             state, state_next;
   logic [15:0]        len;
   logic [IDX_W-1:0]   word_idx;
   logic [7:0]         checksum;
   logic               core_rel;
   logic               rx_ready, busy, err, wr;
   logic               accept, sync_hit, word_full;
   logic [15:0]        len_full, idx_inc;
   logic [31:0]        word;

   assign accept   = rx_valid_i && rx_ready;
   assign sync_hit = accept && (rx_data_i == SYNC_BYTE);
   assign len_full = {rx_data_i, len[7:0]};
   // word count compared at 16 bits so LEN == MAX_WORDS terminates before word_idx wraps
   assign idx_inc  = 16'(word_idx) + 16'd1;

   word_packer u_packer (
      .clk   (clk_i),
      .rst_n (reset_i),
      .clear (sync_hit && (state == S_IDLE || state == S_ERROR)),
      .load  (accept && state == S_DATA),
      .din   (rx_data_i),
      .word  (word),
      .full  (word_full)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_ERROR: if (sync_hit) state_next = S_LEN_LO;
         S_LEN_LO:        if (accept) state_next = S_LEN_HI;
         S_LEN_HI: begin
            if (accept) begin
               if (len_full == 16'd0 || len_full > 16'(MAX_WORDS)) state_next = S_ERROR;
               else                                                state_next = S_DATA;
            end
         end
         S_DATA:          if (word_full) state_next = S_WRITE;
         S_WRITE:         state_next = (idx_inc == len) ? S_CHK : S_DATA;
         S_CHK: begin
            if (accept) state_next = (rx_data_i == checksum) ? S_DONE : S_ERROR;
         end
         S_DONE:          state_next = S_DONE;
         default:         state_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_ready = 1'b1;
      busy     = 1'b0;
      err      = 1'b0;
      wr       = 1'b0;
      case (state)
         S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: busy = 1'b1;
         S_WRITE: begin
            busy     = 1'b1;
            rx_ready = 1'b0;
            wr       = 1'b1;
         end
         S_DONE:  rx_ready = 1'b0;
         S_ERROR: err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         len      <= '0;
         word_idx <= '0;
         checksum <= '0;
         core_rel <= 1'b0;
      end else begin
         core_rel <= core_rel || (state == S_DONE);
         case (state)
            S_IDLE, S_ERROR: begin
               if (sync_hit) begin
                  len      <= '0;
                  word_idx <= '0;
                  checksum <= '0;
               end
            end
            S_LEN_LO: if (accept) len[7:0] <= rx_data_i;
            S_LEN_HI: begin
               if (accept) begin
                  len[15:8] <= rx_data_i;
                  word_idx  <= '0;
               end
            end
            S_DATA:   if (accept) checksum <= checksum ^ rx_data_i;
            S_WRITE:  word_idx <= word_idx + IDX_W'(1);
            default: ;
         endcase
      end
   end

   assign rx_ready_o   = rx_ready;
   assign busy_o       = busy;
   assign err_o        = err;
   assign core_reset_o = core_rel;
   assign mem_wmask_o  = WMASK_WORD;
   assign mem_data_o   = wr ? word : '0;
   assign mem_wen_o    = core_rel ? 1'b1 : !wr;
   assign mem_addr_o   = core_rel ? core_instr_addr_i
                                  : (wr ? {word_idx, 2'b00} : '0);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader with a queue-based expected-write model.
module tb_prog_loader;

   typedef struct packed {
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rx_data_i = '0;
   logic [10:0] core_instr_addr_i = '0;
   logic        rx_ready_o, core_reset_o, mem_wen_o, busy_o, err_o;
   logic [10:0] mem_addr_o;
   logic [3:0]  mem_wmask_o;
   logic [31:0] mem_data_o;

   always #5 clk_i = ~clk_i;

   prog_loader #(.ADDR_W(11), .MAX_WORDS(512), .SYNC_BYTE(8'hA5)) dut (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .rx_valid_i        (rx_valid_i),
      .rx_data_i         (rx_data_i),
      .rx_ready_o        (rx_ready_o),
      .core_instr_addr_i (core_instr_addr_i),
      .core_reset_o      (core_reset_o),
      .mem_addr_o        (mem_addr_o),
      .mem_wen_o         (mem_wen_o),
      .mem_wmask_o       (mem_wmask_o),
      .mem_data_o        (mem_data_o),
      .busy_o            (busy_o),
      .err_o             (err_o)
   );

   int unsigned n_checks = 0, n_fail = 0;
   bit          check_en = 0, addr_rand = 1;
   bit          exp_busy = 0, exp_err = 0, exp_core = 0, exp_done = 0;
   wr_t         exp_q[$];
   int unsigned wr_cnt = 0, ready_low_cnt = 0;
   logic [10:0] last_addr = '0;
   logic [31:0] last_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      #1;
      if (addr_rand) core_instr_addr_i = 11'($urandom);
   end

   // Per-cycle comparison against the frame-level model
   always @(negedge clk_i) begin
      if (check_en && reset_i) begin
         check("busy", busy_o, exp_busy);
         check("err", err_o, exp_err);
         check("core_reset", core_reset_o, exp_core);
         if (exp_busy && !rx_ready_o) ready_low_cnt++;
         if (exp_core) begin
            check("addr_mux", mem_addr_o, core_instr_addr_i);
            check("wen_core", mem_wen_o, 1);
         end else if (!mem_wen_o) begin
            wr_cnt++;
            last_addr = mem_addr_o;
            last_data = mem_data_o;
            check("ready_in_write", rx_ready_o, 0);
            check("wr_mask", mem_wmask_o, 4'hF);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none required at %0t",
                        mem_addr_o, mem_data_o, $time);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               check("wr_addr", mem_addr_o, w.addr);
               check("wr_data", mem_data_o, w.data);
            end
         end else begin
            check("idle_addr", mem_addr_o, 0);
            check("idle_data", mem_data_o, 0);
            check("ready", rx_ready_o, !exp_done);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit hold);
      bit r;
      int unsigned t;
      if (!hold) begin
         rx_valid_i = 1'b0;
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
         #1;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      t = 0;
      forever begin
         @(negedge clk_i);
         r = rx_ready_o;
         @(posedge clk_i);
         if (r) break;
         t++;
         if (t > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: byte 0x%0h not accepted within 50 cycles", b);
            break;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      check_en   = 0;
      rx_valid_i = 1'b0;
      reset_i    = 1'b0;
      exp_q.delete();
      exp_busy = 0; exp_err = 0; exp_core = 0; exp_done = 0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_core", core_reset_o, 0);
      check("rst_ready", rx_ready_o, 1);
      check("rst_wen", mem_wen_o, 1);
      check("rst_wmask", mem_wmask_o, 4'hF);
      check("rst_data", mem_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      @(negedge clk_i);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_en = 1;
   endtask

   // mode: 0 random payload (with stray sync bytes), 1 data=index, 2 0xDEADBEEF
   task automatic send_frame(input int unsigned len, input int mode, input bit bad_chk, input bit hold);
      logic [7:0]  b, chk;
      logic [31:0] w;
      logic [15:0] l16;
      chk = '0;
      l16 = 16'(len);
      if (!hold) repeat ($urandom_range(0, 2)) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         send_byte(b, 0);
      end
      wr_cnt = 0;
      ready_low_cnt = 0;
      send_byte(8'hA5, hold);
      exp_busy = 1; exp_err = 0;
      send_byte(l16[7:0], hold);
      send_byte(l16[15:8], hold);
      for (int unsigned i = 0; i < len; i++) begin
         if (mode == 1)      w = i;
         else if (mode == 2) w = 32'hDEADBEEF;
         else begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[7:0] = 8'hA5;
         end
         exp_q.push_back({11'(i * 4), w});
         for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            chk = chk ^ b;
            send_byte(b, hold);
         end
      end
      send_byte(bad_chk ? (chk ^ 8'h22) : chk, hold);
      rx_valid_i = 1'b0;
      exp_busy = 0;
      check("write_count", wr_cnt, len);
      check("ready_low_cycles", ready_low_cnt, len);
      check("queue_drained", exp_q.size(), 0);
      if (bad_chk) begin
         exp_err = 1;
         check("err_after_bad_chk", err_o, 1);
      end else begin
         exp_done = 1;
         check("core_not_yet", core_reset_o, 0);
         @(posedge clk_i);
         #1;
         exp_core = 1;
         check("core_rises", core_reset_o, 1);
      end
   endtask

   task automatic send_bad_len(input logic [15:0] l16);
      send_byte(8'hA5, 0);
      exp_busy = 1; exp_err = 0;
      send_byte(l16[7:0], 0);
      send_byte(l16[15:8], 0);
      rx_valid_i = 1'b0;
      exp_busy = 0; exp_err = 1;
      check("bad_len_err", err_o, 1);
      check("bad_len_nowrite", mem_wen_o, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset();

      send_frame(1, 2, 0, 0);
      check("deadbeef_addr", last_addr, 11'h000);
      check("deadbeef_data", last_data, 32'hDEADBEEF);
      check("err_clear", err_o, 0);
      addr_rand = 0;
      core_instr_addr_i = 11'h010;
      #1;
      check("mux_010", mem_addr_o, 11'h010);
      check("mux_wen", mem_wen_o, 1);
      addr_rand = 1;

      do_reset();
      send_frame(1, 2, 1, 0);
      check("bad_chk_core", core_reset_o, 0);
      send_frame(1, 2, 0, 0);
      check("recover_err", err_o, 0);

      do_reset();
      send_bad_len(16'd0);
      send_bad_len(16'd513);
      send_frame(3, 0, 0, 0);

      do_reset();
      send_frame(2, 0, 0, 1);
      check("held_ready_low", ready_low_cnt, 2);

      do_reset();
      send_frame(512, 1, 0, 0);
      check("full_last_addr", last_addr, 11'h7FC);
      check("full_last_data", last_data, 32'h1FF);

      do_reset();
      send_byte(8'hA5, 0);
      exp_busy = 1;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      rx_valid_i = 1'b0;
      #2;
      check_en = 0;
      reset_i  = 1'b0;
      #1;
      check("mid_rst_core", core_reset_o, 0);
      check("mid_rst_ready", rx_ready_o, 1);
      check("mid_rst_wen", mem_wen_o, 1);
      check("mid_rst_data", mem_data_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_err", err_o, 0);
      check("mid_rst_addr", mem_addr_o, 0);
      exp_busy = 0;
      @(negedge clk_i);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_en = 1;
      send_frame(2, 0, 0, 0);

      for (int it = 0; it < 6; it++) begin
         do_reset();
         if ($urandom_range(0, 1) == 1) send_bad_len(16'(513 + $urandom_range(0, 1000)));
         if ($urandom_range(0, 1) == 1) send_frame($urandom_range(1, 6), 0, 1, 0);
         send_frame($urandom_range(1, 8), 0, 0, $urandom_range(0, 1) == 1);
      end

      repeat (3) @(posedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
